// File: rtl/reg_file.sv
// Register file with a hardwired-zero r0, per-register busy scoreboard and two
// registered, tri-stated read buses. Optional same-edge write bypass: REGFILE_BYPASS_EN.
`ifndef DATA_W
`define DATA_W 8
`endif

module reg_file #(
  parameter int DATA_W = `DATA_W,
  parameter int NREG   = 8,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] c,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              latch,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              bath_a,
  input  logic              bath_b,
  output tri   [DATA_W-1:0] a,
  output tri   [DATA_W-1:0] b,
  output logic              a_busy,
  output logic              b_busy
);

  localparam logic [ADDR_W:0] NREG_L = (ADDR_W + 1)'(NREG);

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;

  logic [DATA_W:0]   a_next, b_next;
  logic [DATA_W-1:0] a_q, b_q;
  logic              a_en_q, b_en_q;
  logic              a_busy_q, b_busy_q;

  // Entry 0 is only ever cleared, so it stays zero and never busy.
  // Addresses >= NREG match no entry, so out-of-range writes/reserves fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (latch && c_addr == ADDR_W'(i)) mem[i] <= c;
        // A reserve landing on the same edge as the write is the newer producer.
        if (rsv && rsv_addr == ADDR_W'(i))
          busy[i] <= 1'b1;
        else if (latch && c_addr == ADDR_W'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  // Returns {busy, data} for a read sampled at the coming edge.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] r;
    r = '0;
    if (addr != '0 && {1'b0, addr} < NREG_L) begin
      r = {busy[addr], mem[addr]};
`ifdef REGFILE_BYPASS_EN
      if (latch && c_addr == addr)
        r = {(rsv && rsv_addr == addr), c};
`else
`endif
    end
    return r;
  endfunction

  always_comb begin
    a_next = read_port(a_addr);
    b_next = read_port(b_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      a_en_q   <= 1'b0;
      b_en_q   <= 1'b0;
      a_busy_q <= 1'b0;
      b_busy_q <= 1'b0;
    end else begin
      a_q      <= a_next[DATA_W-1:0];
      b_q      <= b_next[DATA_W-1:0];
      a_en_q   <= bath_a;
      b_en_q   <= bath_b;
      a_busy_q <= a_next[DATA_W];
      b_busy_q <= b_next[DATA_W];
    end
  end

  assign a      = a_en_q ? a_q : 'z;
  assign b      = b_en_q ? b_q : 'z;
  assign a_busy = a_busy_q;
  assign b_busy = b_busy_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed test of reg_file (NREG=6, DATA_W=8). Buses carry weak pull-ups,
// so an undriven bus reads as all ones.
module tb_reg_file;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam logic [DW-1:0] IDLE = 8'hFF;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] c;
  logic [AW-1:0] c_addr, rsv_addr, a_addr, b_addr;
  logic          latch, rsv, bath_a, bath_b;
  wire  [DW-1:0] a, b;
  logic          a_busy, b_busy;

  int total = 0;
  int bad   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  pullup (a);
  pullup (b);

  reg_file #(.DATA_W(DW), .NREG(6), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .c(c), .c_addr(c_addr), .latch(latch),
    .rsv(rsv), .rsv_addr(rsv_addr), .a_addr(a_addr), .b_addr(b_addr),
    .bath_a(bath_a), .bath_b(bath_b), .a(a), .b(b),
    .a_busy(a_busy), .b_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl;
    latch = 1'b0;
    rsv   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; c = '0; c_addr = '0; latch = 1'b0; rsv = 1'b0; rsv_addr = '0;
    a_addr = '0; b_addr = '0; bath_a = 1'b0; bath_b = 1'b0;
    #1 rst_n = 1'b0;
    step; step;
    check("rst_a_float", a, IDLE);
    check("rst_b_float", b, IDLE);
    check("rst_a_busy", {7'b0, a_busy}, 8'h00);
    rst_n = 1'b1;

    // Reads after reset return zero
    a_addr = 3'd3; bath_a = 1'b1; b_addr = 3'd5; bath_b = 1'b1;
    step;
    check("post_rst_a_r3", a, 8'h00);
    check("post_rst_b_r5", b, 8'h00);

    // Write r3 then read it on the next edge
    bath_a = 1'b0; bath_b = 1'b0;
    latch = 1'b1; c_addr = 3'd3; c = 8'hA5;
    step;
    idle_ctl; a_addr = 3'd3; bath_a = 1'b1;
    step;
    check("wr_rd_a_r3", a, 8'hA5);
    check("b_disabled_float", b, IDLE);

    // r0 ignores writes and reserves
    latch = 1'b1; c_addr = 3'd0; c = 8'hFF; rsv = 1'b1; rsv_addr = 3'd0;
    step;
    idle_ctl; a_addr = 3'd0;
    step;
    check("r0_data", a, 8'h00);
    check("r0_busy", {7'b0, a_busy}, 8'h00);

    // Scoreboard on r5
    rsv = 1'b1; rsv_addr = 3'd5;
    step;
    idle_ctl; b_addr = 3'd5; bath_b = 1'b1;
    step;
    check("r5_reserved_busy", {7'b0, b_busy}, 8'h01);
    latch = 1'b1; c_addr = 3'd5; c = 8'h12;
    step;
    check("r5_same_edge_busy", {7'b0, b_busy}, BYP ? 8'h00 : 8'h01);
    check("r5_same_edge_data", b, BYP ? 8'h12 : 8'h00);
    idle_ctl;
    step;
    check("r5_written_busy", {7'b0, b_busy}, 8'h00);
    check("r5_written_data", b, 8'h12);
    latch = 1'b1; c_addr = 3'd5; c = 8'h34; rsv = 1'b1; rsv_addr = 3'd5;
    step;
    idle_ctl;
    step;
    check("r5_wr_rsv_busy", {7'b0, b_busy}, 8'h01);
    check("r5_wr_rsv_data", b, 8'h34);

    // Same-edge write/read of r2
    latch = 1'b1; c_addr = 3'd2; c = 8'h11;
    step;
    c = 8'h3C; a_addr = 3'd2; bath_a = 1'b1;
    step;
    check("bypass_r2", a, BYP ? 8'h3C : 8'h11);
    check("bypass_r2_busy", {7'b0, a_busy}, 8'h00);
    idle_ctl;
    step;
    check("r2_after", a, 8'h3C);

    // Out-of-range address 7 (NREG=6)
    latch = 1'b1; c_addr = 3'd7; c = 8'hEE; rsv = 1'b1; rsv_addr = 3'd7;
    step;
    c_addr = 3'd6; rsv_addr = 3'd6;
    step;
    idle_ctl; a_addr = 3'd7; b_addr = 3'd3;
    step;
    check("oor_a_data", a, 8'h00);
    check("oor_a_busy", {7'b0, a_busy}, 8'h00);
    check("oor_r3_intact", b, 8'hA5);
    a_addr = 3'd1; b_addr = 3'd4;
    step;
    check("oor_r1_intact", a, 8'h00);
    check("oor_r4_intact", b, 8'h00);

    // Asynchronous reset mid-cycle while buses driven and r5 busy
    b_addr = 3'd5;
    step;
    check("pre_rst_b_busy", {7'b0, b_busy}, 8'h01);
    #3 rst_n = 1'b0;
    #1;
    check("async_a_float", a, IDLE);
    check("async_b_float", b, IDLE);
    check("async_a_busy", {7'b0, a_busy}, 8'h00);
    check("async_b_busy", {7'b0, b_busy}, 8'h00);
    latch = 1'b1; c_addr = 3'd4; c = 8'h77; rsv = 1'b1; rsv_addr = 3'd4;
    step;
    check("held_rst_a_float", a, IDLE);
    rst_n = 1'b1; idle_ctl; a_addr = 3'd4; b_addr = 3'd3;
    step;
    check("rst_blocks_wr_r4", a, 8'h00);
    check("rst_clears_r3", b, 8'h00);
    check("rst_blocks_rsv_r4", {7'b0, a_busy}, 8'h00);
    b_addr = 3'd5;
    step;
    check("rst_clears_busy_r5", {7'b0, b_busy}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
